// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I-subset multicycle control FSM (lw, sw, R/I ALU ops, beq, jal)
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] IMMSrc,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // fetch/branch/jump are kept as qualifiers so PCWrite and IRWrite can
    // follow mem_ready and zero within the same cycle.
    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] imm_src;
        logic       trap;
        logic       fetch;
        logic       branch;
        logic       jump;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(input state_t s, input logic is_store,
                                       input logic [2:0] alu_fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.fetch      = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.imm_src   = 2'b10;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.imm_src   = is_store ? 2'b01 : 2'b00;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = alu_fn;
            end
            S_EXECUTEI: begin
                c.alu_src_a   = 2'b10;
                c.alu_src_b   = 2'b01;
                c.alu_control = alu_fn;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a   = 2'b10;
                c.alu_control = ALU_SUB;
                c.branch      = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.imm_src   = 2'b11;
                c.jump      = 1'b1;
            end
            S_TRAP: c.trap = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [2:0] alu_dec;

    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Outputs are registered against the state being entered; op/funct3 come
    // from the instruction register and are stable for the whole instruction.
    always_comb ctrl_d = ctrl_for(state_d, op[5], alu_dec);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_for(S_FETCH, 1'b0, ALU_ADD);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign IRWrite    = ~rst & ctrl_q.fetch & mem_ready;
    assign PCWrite    = (~rst & ctrl_q.fetch & mem_ready) | (ctrl_q.branch & zero) | ctrl_q.jump;
    assign AdrSrc     = ctrl_q.adr_src;
    assign MemWrite   = ctrl_q.mem_write;
    assign RegWrite   = ctrl_q.reg_write;
    assign ResultSrc  = ctrl_q.result_src;
    assign ALUSrcA    = ctrl_q.alu_src_a;
    assign ALUSrcB    = ctrl_q.alu_src_b;
    assign ALUControl = ctrl_q.alu_control;
    assign IMMSrc     = ctrl_q.imm_src;
    assign illegal    = ctrl_q.trap;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst, funct7b5, zero, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, IMMSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .IMMSrc(IMMSrc), .illegal(illegal), .state(state)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         lat;
        logic [2:0] alu;
        logic       pcw;
    } vec_t;

    vec_t vecs[12];

    task automatic run_instr(input vec_t v, output int lat, output logic [2:0] alu,
                             output logic pcw);
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z; mem_ready = 1'b1;
        lat = 1; alu = 3'bxxx; pcw = 1'bx;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (state == 4'd0) break;
            lat++;
            if (lat == 3) begin alu = ALUControl; pcw = PCWrite; end
        end
    endtask

    // Reference model: an instruction is the list of states the spec prescribes
    // for its opcode; FETCH/MEMREAD/MEMWRITE stall while mem_ready is low.
    int path[$];
    int idx;

    function automatic void set_path(input logic [6:0] o);
        path.delete();
        path.push_back(0);
        path.push_back(1);
        case (o)
            OP_LW:  begin path.push_back(2); path.push_back(3); path.push_back(4); end
            OP_SW:  begin path.push_back(2); path.push_back(5); end
            OP_R:   begin path.push_back(6); path.push_back(8); end
            OP_I:   begin path.push_back(7); path.push_back(8); end
            OP_BEQ: path.push_back(9);
            OP_JAL: begin path.push_back(10); path.push_back(8); end
            default: path.push_back(11);
        endcase
    endfunction

    function automatic logic [20:0] expect_out(input int s, input logic [6:0] o,
            input logic [2:0] f3, input logic f7, input logic z, input logic mr, input logic r);
        logic pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu, fdec;
        logic [3:0] s4;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 0; sa = 0; sb = 0; imm = 0; alu = 0;
        s4 = s[3:0];
        case (f3)
            3'd0: fdec = (o[5] && f7) ? 3'b001 : 3'b000;
            3'd2: fdec = 3'b101;
            3'd6: fdec = 3'b011;
            3'd7: fdec = 3'b010;
            default: fdec = 3'b000;
        endcase
        case (s)
            0:  begin sb = 2; rs = 2; irw = mr && !r; pcw = mr && !r; end
            1:  begin sa = 1; sb = 1; imm = 2; end
            2:  begin sa = 2; sb = 1; imm = (o == OP_SW) ? 2'd1 : 2'd0; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; alu = fdec; end
            7:  begin sa = 2; sb = 1; alu = fdec; end
            8:  rw = 1;
            9:  begin sa = 2; alu = 3'b001; pcw = z; end
            10: begin sa = 1; sb = 2; imm = 3; pcw = 1; end
            default: ill = 1;
        endcase
        return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill, s4};
    endfunction

    task automatic new_instr();
        int r;
        r = $urandom_range(0, 12);
        case (r)
            0, 1:   op = OP_LW;
            2, 3:   op = OP_SW;
            4, 5:   op = OP_R;
            6, 7:   op = OP_I;
            8, 9:   op = OP_BEQ;
            10, 11: op = OP_JAL;
            default: begin
                r = $urandom_range(0, 2);
                op = (r == 0) ? 7'h7F : ((r == 1) ? 7'h00 : 7'h37);
            end
        endcase
        funct3 = 3'($urandom_range(0, 7));
        funct7b5 = 1'($urandom_range(0, 1));
        set_path(op);
        idx = 0;
    endtask

    initial begin
        int lat, mw_cnt, trap_ok, trap_cycles, cur;
        logic [2:0] alu;
        logic pcw, rw_seen;
        logic [20:0] act;
        int lw_st[6];

        rst = 1; op = OP_LW; funct3 = 0; funct7b5 = 0; zero = 0; mem_ready = 1;
        @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_irwrite", IRWrite, 0);
        chk("reset_pcwrite", PCWrite, 0);
        chk("reset_alusrcb", ALUSrcB, 2'b10);
        chk("reset_resultsrc", ResultSrc, 2'b10);
        chk("reset_adrsrc", AdrSrc, 0);
        @(posedge clk); #1 rst = 0;

        vecs[0]  = '{OP_LW,  3'd2, 1'b0, 1'b0, 5, 3'b000, 1'b0};
        vecs[1]  = '{OP_SW,  3'd2, 1'b0, 1'b0, 4, 3'b000, 1'b0};
        vecs[2]  = '{OP_R,   3'd0, 1'b1, 1'b0, 4, 3'b001, 1'b0};
        vecs[3]  = '{OP_R,   3'd0, 1'b0, 1'b0, 4, 3'b000, 1'b0};
        vecs[4]  = '{OP_R,   3'd7, 1'b0, 1'b0, 4, 3'b010, 1'b0};
        vecs[5]  = '{OP_R,   3'd6, 1'b0, 1'b0, 4, 3'b011, 1'b0};
        vecs[6]  = '{OP_R,   3'd2, 1'b0, 1'b0, 4, 3'b101, 1'b0};
        vecs[7]  = '{OP_I,   3'd0, 1'b1, 1'b0, 4, 3'b000, 1'b0};
        vecs[8]  = '{OP_BEQ, 3'd0, 1'b0, 1'b1, 3, 3'b001, 1'b1};
        vecs[9]  = '{OP_BEQ, 3'd0, 1'b0, 1'b0, 3, 3'b001, 1'b0};
        vecs[10] = '{OP_JAL, 3'd0, 1'b0, 1'b0, 4, 3'b000, 1'b1};
        vecs[11] = '{OP_R,   3'd1, 1'b1, 1'b0, 4, 3'b000, 1'b0};

        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i], lat, alu, pcw);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d_alucontrol", i), alu, vecs[i].alu);
            chk($sformatf("vec%0d_pcwrite", i), pcw, vecs[i].pcw);
        end

        lw_st = '{0, 1, 2, 3, 4, 0};
        op = OP_LW; mem_ready = 1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("lw_state_c%0d", i), state, lw_st[i]);
            chk($sformatf("lw_regwrite_c%0d", i), RegWrite, (i == 4));
            if (i == 2) chk("lw_immsrc", IMMSrc, 2'b00);
            if (i < 5) begin @(posedge clk); #1; end
        end

        op = OP_SW; mem_ready = 1; mw_cnt = 0; rw_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (state == 4'd0) break;
            mem_ready = !(state == 4'd5 && mw_cnt < 3);
            if (MemWrite) mw_cnt++;
            rw_seen |= RegWrite;
        end
        mem_ready = 1;
        chk("sw_memwrite_cycles", mw_cnt, 4);
        chk("sw_regwrite_never", rw_seen, 0);
        chk("sw_back_to_fetch", state, 0);

        op = 7'h7F;
        @(posedge clk); #1;
        @(posedge clk); #1;
        trap_ok = 0;
        for (int i = 0; i < 12; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            #1;
            if (state == 4'd11 && illegal && !PCWrite && !IRWrite && !RegWrite && !MemWrite)
                trap_ok++;
            @(posedge clk); #1;
        end
        chk("trap_held_cycles", trap_ok, 12);
        @(negedge clk); rst = 1; #1;
        chk("trap_reset_state", state, 0);
        chk("trap_reset_illegal", illegal, 0);
        @(posedge clk); #1 rst = 0; op = OP_LW; mem_ready = 1; zero = 0;

        rw_seen = 0;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; rw_seen |= RegWrite; end
        chk("memread_reached", state, 3);
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; rw_seen |= RegWrite; end
        chk("memread_hold", state, 3);
        @(negedge clk); #2 rst = 1; #1;
        chk("async_reset_state", state, 0);
        rw_seen |= RegWrite;
        @(posedge clk); #1 rst = 0; mem_ready = 1; rw_seen |= RegWrite;
        chk("reset_regwrite_never", rw_seen, 0);
        @(posedge clk); #1;
        chk("first_edge_after_reset", state, 1);
        for (int i = 0; i < 10 && state != 4'd0; i++) begin @(posedge clk); #1; end
        chk("random_start_fetch", state, 0);

        rst = 0; trap_cycles = 0;
        new_instr();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            cur = path[idx];
            act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                   ALUSrcB, ALUControl, IMMSrc, illegal, state};
            chk($sformatf("random_c%0d", c), act,
                expect_out(cur, op, funct3, funct7b5, zero, mem_ready, rst));
            @(posedge clk); #1;
            if (rst) begin
                rst = 0;
                new_instr();
            end else if (cur == 11) begin
                trap_cycles++;
                if (trap_cycles >= 4) begin rst = 1; trap_cycles = 0; idx = 0; end
            end else if ((cur == 0 || cur == 3 || cur == 5) && !mem_ready) begin
                idx = idx;
            end else begin
                idx++;
                if (idx == path.size()) new_instr();
            end
            zero = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
